// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - state encodings, default phase lengths and timer helpers for the fighter controller
package fighter_pkg;

  localparam int TMR_W = 5;

  localparam int DEF_JUMP_TICKS    = 16;
  localparam int DEF_WINDUP_TICKS  = 2;
  localparam int DEF_ACTIVE_TICKS  = 3;
  localparam int DEF_RECOVER_TICKS = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WALK    = 3'd1,
    ST_JUMP    = 3'd2,
    ST_WINDUP  = 3'd3,
    ST_ACTIVE  = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  // Phase timers count down from N-1 and release the phase on the tick that reads zero.
  function automatic logic [TMR_W-1:0] tmr_load(input int n);
    return TMR_W'(n - 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchroniser, stability debounce and rising-edge strobe for one raw button
module btn_debounce #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  logic            r_s1;
  logic            r_s2;
  logic            r_level;
  logic            r_rise;
  logic [DB_W-1:0] r_cnt;
  logic            w_flip;

  // The level flips on the DB_CYCLES-th consecutive sample that disagrees with it.
  assign w_flip = (r_s2 != r_level) && (r_cnt == DB_W'(DB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1   <= i_btn;
      r_s2   <= r_s1;
      r_rise <= w_flip & ~r_level;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/fighter_action_ctrl.sv
// rtl/fighter_action_ctrl.sv - per-player button conditioning and tick-driven walk/jump/attack FSM
// Define ATTACK_BUFFER_EN to keep one attack press made during ACTIVE/RECOVER and chain it into WINDUP.
module fighter_action_ctrl
  import fighter_pkg::*;
#(
  parameter int PLAYER_NO     = 0,
  parameter int DB_CYCLES     = 500000,
  parameter int DB_W          = 20,
  parameter int JUMP_TICKS    = DEF_JUMP_TICKS,
  parameter int WINDUP_TICKS  = DEF_WINDUP_TICKS,
  parameter int ACTIVE_TICKS  = DEF_ACTIVE_TICKS,
  parameter int RECOVER_TICKS = DEF_RECOVER_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       btn_attack,
  output logic       moving_left,
  output logic       moving_right,
  output logic       jump_req,
  output logic       attack_hit,
  output logic       busy,
  output logic       facing,
  output logic [2:0] state
);

  logic [3:0] w_btn;
  logic [3:0] w_lvl;
  logic [3:0] w_rise;
  logic       w_unused_rise;

  assign w_btn = {btn_attack, btn_jump, btn_right, btn_left};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .DB_W     (DB_W)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .i_btn  (w_btn[g]),
      .o_level(w_lvl[g]),
      .o_rise (w_rise[g])
    );
  end

  // Direction buttons are consumed as levels; their edges have no use.
  assign w_unused_rise = &{1'b0, w_rise[1:0]};

  logic r_tick_d;
  logic r_jump_pend;
  logic r_att_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_d    <= 1'b0;
      r_jump_pend <= 1'b0;
      r_att_pend  <= 1'b0;
    end else begin
      r_tick_d <= tick;
      if (r_tick_d) begin
        r_jump_pend <= w_rise[2];
        r_att_pend  <= w_rise[3];
      end else begin
        if (w_rise[2]) r_jump_pend <= 1'b1;
        if (w_rise[3]) r_att_pend  <= 1'b1;
      end
    end
  end

  logic w_hold_l;
  logic w_hold_r;

  assign w_hold_l = w_lvl[0] & ~w_lvl[1];
  assign w_hold_r = w_lvl[1] & ~w_lvl[0];

  state_t           r_state;
  state_t           w_state_n;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_n;
  logic             r_ml, w_ml_n;
  logic             r_mr, w_mr_n;
  logic             r_jr, w_jr_n;
  logic             r_facing, w_facing_n;
  logic             r_buf, w_buf_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_tmr    <= '0;
      r_ml     <= 1'b0;
      r_mr     <= 1'b0;
      r_jr     <= 1'b0;
      r_facing <= (PLAYER_NO == 0);
      r_buf    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_tmr    <= w_tmr_n;
      r_ml     <= w_ml_n;
      r_mr     <= w_mr_n;
      r_jr     <= w_jr_n;
      r_facing <= w_facing_n;
      r_buf    <= w_buf_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_tmr_n    = r_tmr;
    w_ml_n     = r_ml;
    w_mr_n     = r_mr;
    w_jr_n     = r_jr;
    w_facing_n = r_facing;
    w_buf_n    = r_buf;
    if (tick) begin
      w_ml_n = 1'b0;
      w_mr_n = 1'b0;
      w_jr_n = 1'b0;
      case (r_state)
        ST_IDLE, ST_WALK: begin
          if (r_att_pend) begin
            w_state_n = ST_WINDUP;
            w_tmr_n   = tmr_load(WINDUP_TICKS);
          end else if (r_jump_pend) begin
            w_state_n = ST_JUMP;
            w_tmr_n   = tmr_load(JUMP_TICKS);
            w_jr_n    = 1'b1;
            w_ml_n    = w_hold_l;
            w_mr_n    = w_hold_r;
          end else begin
            w_state_n = (w_hold_l | w_hold_r) ? ST_WALK : ST_IDLE;
            w_ml_n    = w_hold_l;
            w_mr_n    = w_hold_r;
          end
        end
        ST_JUMP: begin
          w_ml_n = w_hold_l;
          w_mr_n = w_hold_r;
          if (r_tmr == '0) w_state_n = (w_hold_l | w_hold_r) ? ST_WALK : ST_IDLE;
          else             w_tmr_n   = r_tmr - 1'b1;
        end
        ST_WINDUP: begin
          if (r_tmr == '0) begin
            w_state_n = ST_ACTIVE;
            w_tmr_n   = tmr_load(ACTIVE_TICKS);
          end else begin
            w_tmr_n = r_tmr - 1'b1;
          end
        end
        ST_ACTIVE: begin
`ifdef ATTACK_BUFFER_EN
          if (r_att_pend) w_buf_n = 1'b1;
`endif
          if (r_tmr == '0) begin
            w_state_n = ST_RECOVER;
            w_tmr_n   = tmr_load(RECOVER_TICKS);
          end else begin
            w_tmr_n = r_tmr - 1'b1;
          end
        end
        ST_RECOVER: begin
          if (r_tmr == '0) begin
`ifdef ATTACK_BUFFER_EN
            if (r_buf || r_att_pend) begin
              w_state_n = ST_WINDUP;
              w_tmr_n   = tmr_load(WINDUP_TICKS);
              w_buf_n   = 1'b0;
            end else begin
              w_state_n = ST_IDLE;
            end
`else
            w_state_n = ST_IDLE;
`endif
          end else begin
            w_tmr_n = r_tmr - 1'b1;
`ifdef ATTACK_BUFFER_EN
            if (r_att_pend) w_buf_n = 1'b1;
`endif
          end
        end
        default: begin
          w_state_n = ST_IDLE;
          w_tmr_n   = '0;
        end
      endcase
      if (w_ml_n)      w_facing_n = 1'b0;
      else if (w_mr_n) w_facing_n = 1'b1;
    end
  end

  assign moving_left  = r_ml;
  assign moving_right = r_mr;
  assign jump_req     = r_jr;
  assign facing       = r_facing;
  assign state        = r_state;
  assign attack_hit   = (r_state == ST_ACTIVE);
  assign busy         = (r_state == ST_WINDUP) || (r_state == ST_ACTIVE) || (r_state == ST_RECOVER);

endmodule
